// File: rtl/rtype_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-format datapath.
// Owns PC, IR, retire count and every datapath strobe; stops on halt or bad encoding.
module rtype_mc_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        im_valid,
  input  logic [31:0] im_data,
  output logic        im_req,
  output logic [31:0] pc,
  output logic [4:0]  rf_ra,
  output logic [4:0]  rf_rb,
  output logic [4:0]  rf_wa,
  output logic [4:0]  shamt,
  output logic        a_we,
  output logic        b_we,
  output logic        alu_out_we,
  output logic        rf_we,
  output logic [3:0]  alu_ctrl,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t      state, state_nx;
  // opcode is checked at capture time, so only the R-format fields are kept
  logic [25:0] ir;
  logic        cap, cap_halt, cap_bad;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: funct_ok = 1'b1;
      default:                                         funct_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] funct_ctrl(input logic [5:0] f);
    case (f)
      6'h20:   funct_ctrl = 4'b0010;
      6'h22:   funct_ctrl = 4'b0110;
      6'h24:   funct_ctrl = 4'b0000;
      6'h25:   funct_ctrl = 4'b0001;
      6'h2A:   funct_ctrl = 4'b0111;
      6'h00:   funct_ctrl = 4'b1000;
      6'h02:   funct_ctrl = 4'b1001;
      default: funct_ctrl = 4'b0000;
    endcase
  endfunction

  assign rf_ra    = ir[25:21];
  assign rf_rb    = ir[20:16];
  assign rf_wa    = ir[15:11];
  assign shamt    = ir[10:6];
  assign alu_ctrl = funct_ctrl(ir[5:0]);

  assign cap      = (state == S_FETCH) && im_valid;
  assign cap_halt = (im_data == HALT_WORD);
  assign cap_bad  = (im_data[31:26] != 6'd0) || !funct_ok(im_data[5:0]);

  always_comb begin
    state_nx   = state;
    im_req     = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    alu_out_we = 1'b0;
    rf_we      = 1'b0;
    case (state)
      S_FETCH: begin
        // held low while reset is asserted so the bus sees no request
        im_req = rst_n;
        if (im_valid) state_nx = (cap_halt || cap_bad) ? S_HALT : S_DECODE;
      end
      S_DECODE: begin
        a_we     = 1'b1;
        b_we     = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        alu_out_we = 1'b1;
        state_nx   = S_WB;
      end
      S_WB: begin
        rf_we    = (rf_wa != 5'd0);
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= PC_RESET;
      ir      <= '0;
      retired <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (cap) begin
        ir <= im_data[25:0];
        pc <= pc + 32'd4;
        if (cap_halt || cap_bad) halted  <= 1'b1;
        if (!cap_halt && cap_bad) illegal <= 1'b1;
      end
      if (state == S_WB) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_rtype_mc_ctrl.sv
// Directed bench for rtype_mc_ctrl: instruction-level model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_rtype_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_valid = 1'b0;
  logic [31:0] im_data;
  logic        im_req;
  logic [31:0] pc;
  logic [4:0]  rf_ra, rf_rb, rf_wa, shamt;
  logic        a_we, b_we, alu_out_we, rf_we;
  logic [3:0]  alu_ctrl;
  logic        halted, illegal;
  logic [31:0] retired;

  logic [31:0] imem [0:15];
  int          errors = 0;
  int          checks = 0;

  // instruction memory answers for the address the DUT presents
  assign im_data = imem[pc[5:2]];

  rtype_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .im_valid(im_valid), .im_data(im_data),
    .im_req(im_req), .pc(pc), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa),
    .shamt(shamt), .a_we(a_we), .b_we(b_we), .alu_out_we(alu_out_we),
    .rf_we(rf_we), .alu_ctrl(alu_ctrl), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ctrl_of(input logic [5:0] f);
    case (f)
      6'h20: return 4'b0010;  6'h22: return 4'b0110;
      6'h24: return 4'b0000;  6'h25: return 4'b0001;
      6'h2A: return 4'b0111;  6'h00: return 4'b1000;
      6'h02: return 4'b1001;  default: return 4'bxxxx;
    endcase
  endfunction

  // Model: the instruction in flight and how many cycles since it was captured.
  int          m_age;
  bit          m_halt, m_ill;
  logic [31:0] m_pc, m_ir, m_ret;

  task automatic model_reset();
    m_age = 0; m_halt = 0; m_ill = 0;
    m_pc = 32'h0; m_ir = 32'h0; m_ret = 32'h0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check("im_req",     im_req,     rst_n && !m_halt && m_age == 0);
    check("a_we",       a_we,       !m_halt && m_age == 1);
    check("b_we",       b_we,       !m_halt && m_age == 1);
    check("alu_out_we", alu_out_we, !m_halt && m_age == 2);
    check("rf_we",      rf_we,      !m_halt && m_age == 3 && m_ir[15:11] != 0);
    check("pc",         pc,         m_pc);
    check("retired",    retired,    m_ret);
    check("halted",     halted,     m_halt);
    check("illegal",    illegal,    m_ill);
    check("rf_ra",      rf_ra,      m_ir[25:21]);
    check("rf_rb",      rf_rb,      m_ir[20:16]);
    check("rf_wa",      rf_wa,      m_ir[15:11]);
    check("shamt",      shamt,      m_ir[10:6]);
    if (!m_halt && m_age >= 1) check("alu_ctrl", alu_ctrl, ctrl_of(m_ir[5:0]));
    check("one_hot", 32'(a_we) + 32'(alu_out_we) + 32'(rf_we) <= 1, 1);
    if (rst_n && !m_halt) begin
      if (m_age == 0) begin
        if (im_valid) begin
          m_ir = im_data;
          m_pc = m_pc + 4;
          if (im_data == 32'hFFFF_FFFF) m_halt = 1;
          else if (im_data[31:26] != 0 ||
                   !(im_data[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02})) begin
            m_halt = 1; m_ill = 1;
          end else m_age = 1;
        end
      end else if (m_age == 3) begin
        m_age = 0;
        m_ret = m_ret + 1;
      end else m_age = m_age + 1;
    end
  end

  task automatic start(input logic v);
    @(posedge clk); #1 rst_n = 1'b0; im_valid = v;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 16; i++) imem[i] = 32'hFFFF_FFFF;
  endtask

  initial begin
    clear_imem();
    // A: single add $8,$9,$10
    imem[0] = 32'h012A4020;
    start(1'b1);
    @(negedge clk); check("A_fetch_pc", pc, 32'd0); check("A_req", im_req, 1);
    @(negedge clk);
    check("A_ra", rf_ra, 9); check("A_rb", rf_rb, 10); check("A_wa", rf_wa, 8);
    check("A_ctrl", alu_ctrl, 4'b0010); check("A_pc", pc, 32'd4); check("A_awe", a_we, 1);
    @(negedge clk); check("A_alu_we", alu_out_we, 1); check("A_rfwe_early", rf_we, 0);
    @(negedge clk); check("A_rfwe", rf_we, 1);
    @(negedge clk); check("A_ret", retired, 1); check("A_pc_end", pc, 32'd4);
    repeat (4) @(negedge clk);
    check("A_halted", halted, 1); check("A_pc_halt", pc, 32'd8);

    // B: sub/and/or/slt/sll/srl back to back
    clear_imem();
    imem[0] = 32'h00221822; imem[1] = 32'h00222024; imem[2] = 32'h00222825;
    imem[3] = 32'h0022302A; imem[4] = 32'h00023900; imem[5] = 32'h00024842;
    start(1'b1);
    repeat (24) @(posedge clk);
    #1 check("B_ret", retired, 6); check("B_pc", pc, 32'd24); check("B_halt_early", halted, 0);
    repeat (3) @(posedge clk);
    #1 check("B_halted", halted, 1); check("B_ill", illegal, 0);

    // C: three IM wait cycles
    clear_imem();
    imem[0] = 32'h012A4020;
    start(1'b0);
    repeat (3) @(posedge clk);
    #1 check("C_pc_wait", pc, 32'd0); check("C_req_wait", im_req, 1);
    im_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("C_ret_6", retired, 0);
    @(posedge clk);
    #1 check("C_ret_7", retired, 1);
    repeat (6) @(posedge clk);

    // D: all-zero NOP then add $8,$0,$0
    clear_imem();
    imem[0] = 32'h00000000; imem[1] = 32'h00004020;
    start(1'b1);
    repeat (3) @(posedge clk);
    #1 check("D_nop_wb", rf_we, 0);
    repeat (4) @(posedge clk);
    #1 check("D_add_wb", rf_we, 1); check("D_wa", rf_wa, 8);
    @(posedge clk);
    #1 check("D_ret", retired, 2);
    repeat (4) @(posedge clk);

    // E: illegal opcode
    clear_imem();
    imem[0] = 32'h8C000000;
    start(1'b1);
    repeat (12) @(posedge clk);
    #1 check("E_halted", halted, 1); check("E_ill", illegal, 1);
    check("E_ret", retired, 0); check("E_pc", pc, 32'd4);

    // F: halt word
    clear_imem();
    start(1'b1);
    repeat (12) @(posedge clk);
    #1 check("F_halted", halted, 1); check("F_ill", illegal, 0); check("F_pc", pc, 32'd4);

    // G: reset during EXEC of add $5,$1,$2
    clear_imem();
    imem[0] = 32'h00222820;
    start(1'b1);
    repeat (2) @(posedge clk);
    #1 check("G_in_exec", alu_out_we, 1);
    rst_n = 1'b0;
    #1 check("G_pc_rst", pc, 32'd0); check("G_req_rst", im_req, 0);
    check("G_rfwe_rst", rf_we, 0); check("G_alu_rst", alu_out_we, 0);
    check("G_ret_rst", retired, 0); check("G_wa_rst", rf_wa, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 check("G_restart_pc", pc, 32'd0); check("G_restart_req", im_req, 1);
    repeat (4) @(posedge clk);
    #1 check("G_ret", retired, 1);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
